// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM-like memory interface arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while the instruction side was waiting.
module arb_starve_cnt
  import mem_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

  assign sat = (cnt == W'(LIMIT));

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (inst read-only, data read/write) arbiter onto one SRAM-like bus,
// one outstanding transaction at a time, with starvation protection for inst.
module sram_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output state_t      state
);

  // Handshake: a requester holds req until its single-cycle addr_ok; its
  // data_ok (with rdata) is a later single-cycle pulse. Towards the bus,
  // bus_req stays high with a stable payload until bus_addr_ok, after which
  // we wait for bus_data_ok. Handshakes outside their phase are ignored.

  state_t next_state;
  logic   owner_data;
  logic   starve_sat;
  logic   grant_inst;
  logic   grant_data;
  logic   drop_write;

  // resetn gating keeps the combinational addr_ok pulses low during reset.
  assign grant_inst = resetn && (state == ST_IDLE) && inst_req && (!data_req || starve_sat);
  assign grant_data = resetn && (state == ST_IDLE) && data_req && !grant_inst;
  assign drop_write = data_wr && (data_wstrb == 4'b0000);

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .resetn (resetn),
    .inc    (grant_data && inst_req),
    .clr    (grant_inst),
    .sat    (starve_sat)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_data <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= 4'b0000;
      bus_size   <= 2'b00;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else if (grant_inst) begin
      owner_data <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= 4'b0000;
      bus_size   <= SIZE_WORD;
      bus_addr   <= inst_addr;
      bus_wdata  <= '0;
    end else if (grant_data) begin
      owner_data <= 1'b1;
      bus_wr     <= data_wr;
      bus_wstrb  <= data_wstrb;
      bus_size   <= data_size;
      bus_addr   <= data_addr;
      bus_wdata  <= data_wdata;
    end
  end

  always_comb begin
    next_state   = state;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    bus_req      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_inst) begin
          inst_addr_ok = 1'b1;
          next_state   = ST_ADDR;
        end else if (grant_data) begin
          data_addr_ok = 1'b1;
          next_state   = drop_write ? ST_DROP : ST_ADDR;
        end
      end
      ST_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bus_data_ok) begin
          if (owner_data) begin
            data_data_ok = 1'b1;
            data_rdata   = bus_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = bus_rdata;
          end
          next_state = ST_IDLE;
        end
      end
      ST_DROP: begin
        // Store with no byte enables: acknowledge without touching the bus.
        data_data_ok = 1'b1;
        next_state   = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: grant table, directed corner sequences, random run vs reference model.
module tb_sram_arbiter;
  import mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  state_t      state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_wstrb    (bus_wstrb),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .state        (state)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = 4'b0000;
    data_size   = 2'b00;
    data_addr   = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  function automatic logic any_out();
    return |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
             bus_req, bus_wr, bus_wstrb, bus_size, bus_addr, bus_wdata, state};
  endfunction

  // Reset with both requests pending: nothing may be granted while resetn is low.
  task automatic do_reset();
    idle_inputs();
    inst_req = 1'b1;
    data_req = 1'b1;
    resetn   = 1'b0;
    #2;
    check("reset_outputs_zero", any_out(), 0);
    tick();
    idle_inputs();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic       ireq;
    logic       dreq;
    logic       dwr;
    logic [3:0] dwstrb;
    logic       exp_iaok;
    logic       exp_daok;
    state_t     exp_state;
  } vec_t;

  vec_t vecs[8];

  task automatic run_table();
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, ST_IDLE};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, ST_ADDR};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, ST_ADDR};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1, ST_ADDR};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, ST_DROP};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, ST_ADDR};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1, ST_DROP};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, ST_ADDR};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      inst_req   = vecs[i].ireq;
      inst_addr  = 32'h100 + 32'(i);
      data_req   = vecs[i].dreq;
      data_wr    = vecs[i].dwr;
      data_wstrb = vecs[i].dwstrb;
      data_addr  = 32'h200 + 32'(i);
      @(negedge clk);
      check($sformatf("vec%0d_inst_addr_ok", i), inst_addr_ok, vecs[i].exp_iaok);
      check($sformatf("vec%0d_data_addr_ok", i), data_addr_ok, vecs[i].exp_daok);
      tick();
      idle_inputs();
      check($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      check($sformatf("vec%0d_bus_req", i), bus_req, (vecs[i].exp_state == ST_ADDR));
    end
  endtask

  task automatic seq_inst_read();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("ird_c0_addr_ok", inst_addr_ok, 1);
    check("ird_c0_bus_req", bus_req, 0);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    check("ird_c1_bus_req", bus_req, 1);
    check("ird_c1_bus_hdr", {bus_wr, bus_wstrb, bus_size, bus_addr}, {1'b0, 4'h0, SIZE_WORD, 32'h1000});
    check("ird_c1_no_data_ok", inst_data_ok, 0);
    tick();
    @(negedge clk);
    check("ird_c2_data_ok", inst_data_ok, 1);
    check("ird_c2_rdata", inst_rdata, 32'hDEADBEEF);
    check("ird_c2_bus_req", bus_req, 0);
    tick();
    @(negedge clk);
    check("ird_c3_data_ok_low", inst_data_ok, 0);
    check("ird_c3_rdata_zero", inst_rdata, 0);
    idle_inputs();
  endtask

  task automatic seq_collision();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h3000;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h2004; data_wstrb = 4'hF;
    data_size = SIZE_WORD; data_wdata = 32'hCAFEF00D;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
    @(negedge clk);
    check("col_data_addr_ok", data_addr_ok, 1);
    check("col_inst_not_granted", inst_addr_ok, 0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    check("col_bus_write", {bus_req, bus_wr, bus_wstrb, bus_addr}, {1'b1, 1'b1, 4'hF, 32'h2004});
    check("col_bus_wdata", bus_wdata, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    check("col_data_data_ok", data_data_ok, 1);
    check("col_inst_wait", {inst_addr_ok, inst_data_ok}, 0);
    tick();
    @(negedge clk);
    check("col_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    check("col_inst_bus", {bus_req, bus_wr, bus_wstrb, bus_addr}, {1'b1, 1'b0, 4'h0, 32'h3000});
    tick();
    @(negedge clk);
    check("col_inst_data", {inst_data_ok, inst_rdata}, {1'b1, 32'h11111111});
    idle_inputs();
  endtask

  task automatic seq_starve();
    int dcount = 0;
    int igrants = 0;
    int run0 = -1;
    int run1 = -1;
    int budget = 0;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h6000;
    data_req = 1'b1; data_addr = 32'h7000;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    while (igrants < 2 && budget < 80) begin
      @(negedge clk);
      if (data_addr_ok) dcount++;
      if (inst_addr_ok) begin
        if (igrants == 0) run0 = dcount;
        else run1 = dcount;
        dcount = 0;
        igrants++;
      end
      budget++;
      tick();
    end
    check("starve_inst_grants", igrants, 2);
    check("starve_first_run", run0, LIMIT);
    check("starve_after_clear_run", run1, LIMIT);
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic seq_drop();
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h0; data_addr = 32'h8000;
    bus_addr_ok = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check("drop_addr_ok", data_addr_ok, 1);
    check("drop_c0_bus_req", bus_req, 0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    check("drop_data_ok", {data_data_ok, data_rdata}, {1'b1, 32'h0});
    check("drop_c1_bus_req", bus_req, 0);
    tick();
    @(negedge clk);
    check("drop_c2_quiet", {data_data_ok, bus_req}, 0);
    idle_inputs();
  endtask

  task automatic seq_bus_stall();
    logic [70:0] exp_pay;
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_HALF;
    data_addr = 32'h4000; data_wdata = 32'h12345678; data_wstrb = 4'h3;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h55;
    exp_pay = {1'b0, 4'h3, SIZE_HALF, 32'h4000, 32'h12345678};
    @(negedge clk);
    check("stall_addr_ok", data_addr_ok, 1);
    tick();
    data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_addr  = $urandom;
      data_wdata = $urandom;
      @(negedge clk);
      check($sformatf("stall_c%0d_bus_req", i), bus_req, 1);
      check($sformatf("stall_c%0d_payload", i),
            {bus_wr, bus_wstrb, bus_size, bus_addr, bus_wdata}, exp_pay);
      check($sformatf("stall_c%0d_stray_data_ok", i), data_data_ok, 0);
      tick();
    end
    bus_addr_ok = 1'b1;
    @(negedge clk);
    check("stall_accept_bus_req", bus_req, 1);
    check("stall_accept_no_data_ok", data_data_ok, 0);
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    check("stall_data", {data_data_ok, data_rdata}, {1'b1, 32'h55});
    idle_inputs();
  endtask

  task automatic seq_reset_in_data();
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h5000;
    bus_addr_ok = 1'b1;
    @(negedge clk);
    check("rst_inst_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0;
    tick();
    bus_addr_ok = 1'b0;
    @(negedge clk);
    check("rst_in_data_state", state, ST_DATA);
    #1;
    bus_data_ok = 1'b1; bus_rdata = 32'h77777777;
    #1;
    check("rst_data_ok_before_reset", inst_data_ok, 1);
    resetn = 1'b0;
    #1;
    check("rst_outputs_zero_async", any_out(), 0);
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_after_c%0d_no_data_ok", i), {inst_data_ok, data_data_ok, bus_req}, 0);
      tick();
    end
    idle_inputs();
  endtask

  // Reference model: a transaction record (owner + payload) per grant, the
  // grant rule with an integer starvation count, and the bus phase the record is in.
  task automatic rand_run(input int ncyc);
    localparam int NONE = 0, WAIT_ACCEPT = 1, WAIT_DATA = 2, DROP_ACK = 3;
    int          phase = NONE;
    int          starve = 0;
    logic [70:0] exp_q[$];
    bit          own_q[$];
    logic [70:0] pay;
    logic        e_iaok, e_daok, e_idok, e_ddok, e_breq;
    logic [31:0] e_ird, e_drd;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      inst_req    = ($urandom_range(0, 9) < 6);
      inst_addr   = $urandom;
      data_req    = ($urandom_range(0, 9) < 8);
      data_wr     = ($urandom_range(0, 1) == 1);
      data_wstrb  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      data_size   = 2'($urandom_range(0, 2));
      data_addr   = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(0, 2) != 0);
      bus_data_ok = ($urandom_range(0, 1) == 1);
      bus_rdata   = $urandom;
      @(negedge clk);
      e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; e_breq = 0; e_ird = '0; e_drd = '0;
      if (phase == NONE) begin
        if (inst_req && (!data_req || starve == LIMIT)) begin
          e_iaok = 1;
          starve = 0;
          exp_q.push_back({1'b0, 4'h0, SIZE_WORD, inst_addr, 32'h0});
          own_q.push_back(1'b0);
          phase = WAIT_ACCEPT;
        end else if (data_req) begin
          e_daok = 1;
          if (inst_req && starve < LIMIT) starve = starve + 1;
          if (data_wr && data_wstrb == 4'h0) begin
            phase = DROP_ACK;
          end else begin
            exp_q.push_back({data_wr, data_wstrb, data_size, data_addr, data_wdata});
            own_q.push_back(1'b1);
            phase = WAIT_ACCEPT;
          end
        end
      end else if (phase == WAIT_ACCEPT) begin
        e_breq = 1;
        pay = exp_q[0];
        check("rnd_bus_hdr", {bus_wr, bus_wstrb, bus_size, bus_addr}, pay[70:32]);
        if (own_q[0]) check("rnd_bus_wdata", bus_wdata, pay[31:0]);
        if (bus_addr_ok) phase = WAIT_DATA;
      end else if (phase == WAIT_DATA) begin
        if (bus_data_ok) begin
          if (own_q[0]) begin e_ddok = 1; e_drd = bus_rdata; end
          else begin e_idok = 1; e_ird = bus_rdata; end
          void'(exp_q.pop_front());
          void'(own_q.pop_front());
          phase = NONE;
        end
      end else begin
        e_ddok = 1;
        phase = NONE;
      end
      check("rnd_addr_oks", {inst_addr_ok, data_addr_ok}, {e_iaok, e_daok});
      check("rnd_data_oks", {inst_data_ok, data_data_ok}, {e_idok, e_ddok});
      check("rnd_rdata", {inst_rdata, data_rdata}, {e_ird, e_drd});
      check("rnd_bus_req", bus_req, e_breq);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    #3;
    check("initial_reset_outputs", any_out(), 0);
    tick();
    resetn = 1'b1;
    run_table();
    seq_inst_read();
    seq_collision();
    seq_starve();
    seq_drop();
    seq_bus_stall();
    seq_reset_in_data();
    rand_run(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
